// File: rtl/chan_scan_seq_pkg.sv
// Shared constants and state type for the channel scan sequencer.
// Exports NUM_CH, SEL_W and the IDLE/SCAN state enum.
package chan_scan_pkg;
   localparam int NUM_CH = 16;
   localparam int SEL_W  = 4;

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;
endpackage

// File: rtl/chan_scan_seq_if.sv
// Control and channel-select bundle of the scan sequencer.
// master: start/stop/mode/dwell/mask out; slave: sel/a-d/valid/done out.
interface chan_scan_seq_if #(
   parameter int DWELL_W = 8
);
   import chan_scan_pkg::*;

   logic               start;
   logic               stop;
   logic               mode;
   logic [DWELL_W-1:0] dwell;
   logic [NUM_CH-1:0]  mask;
   logic [SEL_W-1:0]   sel;
   logic               a;
   logic               b;
   logic               c;
   logic               d;
   logic               valid;
   logic               done;

   modport master (
      output start, stop, mode, dwell, mask,
      input  sel, a, b, c, d, valid, done
   );

   modport slave (
      input  start, stop, mode, dwell, mask,
      output sel, a, b, c, d, valid, done
   );
endinterface

// File: rtl/chan_scan_seq_next_find.sv
// Priority search over the channel mask: lowest enabled index and the
// lowest enabled index strictly above cur. Ports: mask, cur, from_start in.
module chan_next_find
   import chan_scan_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  cur,
   input  logic              from_start,
   output logic              found,
   output logic [SEL_W-1:0]  first_idx,
   output logic [SEL_W-1:0]  next_idx
);
   logic             above_found;
   logic [SEL_W-1:0] above_idx;

   // Walk downward so the lowest matching index is the last one written.
   always_comb begin
      first_idx   = '0;
      above_idx   = '0;
      above_found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i]) begin
            first_idx = SEL_W'(i);
         end
         if (mask[i] && (i > int'(cur))) begin
            above_idx   = SEL_W'(i);
            above_found = 1'b1;
         end
      end
      // From IDLE the search covers the whole mask.
      found    = from_start ? (|mask) : above_found;
      next_idx = from_start ? first_idx : above_idx;
   end
endmodule

// File: rtl/chan_scan_seq.sv
// Channel scan sequencer driving a 4-to-16 decoder through sel/a/b/c/d.
// Ports: clk, rst (sync, active-high), bus (slave modport of chan_scan_seq_if).
module chan_scan_seq
   import chan_scan_pkg::*;
#(
   parameter int DWELL_W = 8
) (
   input  logic            clk,
   input  logic            rst,
   chan_scan_seq_if.slave  bus
);
   state_t             state;
   logic [SEL_W-1:0]   sel_q;
   logic [DWELL_W-1:0] cnt;
   logic               valid_q;
   logic               done_q;
   logic               found;
   logic [SEL_W-1:0]   first_idx;
   logic [SEL_W-1:0]   next_idx;

   chan_next_find u_find (
      .mask       (bus.mask),
      .cur        (sel_q),
      .from_start (state == IDLE),
      .found      (found),
      .first_idx  (first_idx),
      .next_idx   (next_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sel_q   <= '0;
         cnt     <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (!bus.stop && bus.start) begin
                  if (found) begin
                     sel_q   <= next_idx;
                     cnt     <= bus.dwell;
                     valid_q <= 1'b1;
                     state   <= SCAN;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            SCAN: begin
               if (bus.stop) begin
                  valid_q <= 1'b0;
                  state   <= IDLE;
               end else if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (found) begin
                  sel_q <= next_idx;
                  cnt   <= bus.dwell;
               end else if (!bus.mode && (|bus.mask)) begin
                  // Continuous mode wraps to the lowest enabled channel.
                  sel_q <= first_idx;
                  cnt   <= bus.dwell;
               end else begin
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.sel   = sel_q;
   assign bus.a     = sel_q[3];
   assign bus.b     = sel_q[2];
   assign bus.c     = sel_q[1];
   assign bus.d     = sel_q[0];
   assign bus.valid = valid_q;
   assign bus.done  = done_q;
endmodule

// File: tb/tb_chan_scan_seq.sv
// Scoreboard bench for chan_scan_seq: expected output cycles are queued
// per scan and popped by a monitor whenever valid or done is seen.
module tb_chan_scan_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [5:0] exp_q[$];
   logic [3:0] last_sel = 4'd0;

   chan_scan_seq_if #(.DWELL_W(8)) bus ();

   chan_scan_seq #(.DWELL_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Monitor: every presented output must match the head of the queue.
   always @(negedge clk) begin
      logic [5:0] e;
      if (!rst && (bus.valid || bus.done)) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out valid=%0b done=%0b sel=%0d",
                     bus.valid, bus.done, bus.sel);
         end else begin
            e = exp_q.pop_front();
            checks++;
            if ({bus.valid, bus.done, bus.sel} !== e) begin
               errors++;
               $display("FAIL out got v=%0b d=%0b sel=%0d exp v=%0b d=%0b sel=%0d",
                        bus.valid, bus.done, bus.sel, e[5], e[4], e[3:0]);
            end
            checks++;
            if ({bus.a, bus.b, bus.c, bus.d} !== e[3:0]) begin
               errors++;
               $display("FAIL abcd got %b exp %b",
                        {bus.a, bus.b, bus.c, bus.d}, e[3:0]);
            end
         end
      end
   end

   // Reference: enabled channels in ascending order, each for dwell+1
   // cycles; single pass ends with a done cycle, continuous cycles for k.
   task automatic push_scan(input logic [15:0] m, input int dw,
                            input bit md, input int k);
      int chans[$];
      int c;
      for (int i = 0; i < 16; i++) if (m[i]) chans.push_back(i);
      if (chans.size() == 0) begin
         exp_q.push_back({2'b01, last_sel});
      end else if (md) begin
         foreach (chans[j])
            for (int r = 0; r <= dw; r++)
               exp_q.push_back({2'b10, 4'(chans[j])});
         last_sel = 4'(chans[chans.size() - 1]);
         exp_q.push_back({2'b01, last_sel});
      end else begin
         for (int n = 0; n < k; n++) begin
            c = chans[(n / (dw + 1)) % chans.size()];
            exp_q.push_back({2'b10, 4'(c)});
            last_sel = 4'(c);
         end
      end
   endtask

   task automatic drain_check(input int bound, input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin
         @(posedge clk);
         n++;
      end
      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s leftover got %0d entries exp 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic run_scan(input logic [15:0] m, input int dw,
                           input bit md, input int k, input string name);
      @(posedge clk);
      #1;
      bus.mask  = m;
      bus.dwell = 8'(dw);
      bus.mode  = md;
      bus.start = 1'b1;
      push_scan(m, dw, md, k);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (m != 16'h0 && !md) begin
         repeat (k - 1) @(posedge clk);
         #1;
         bus.stop = 1'b1;
         @(posedge clk);
         #1;
         bus.stop = 1'b0;
      end
      drain_check(100, name);
   endtask

   task automatic expect_idle(input logic [3:0] s, input string name);
      @(negedge clk);
      checks++;
      if ({bus.valid, bus.done, bus.sel} !== {2'b00, s}) begin
         errors++;
         $display("FAIL %s got v=%0b d=%0b sel=%0d exp v=0 d=0 sel=%0d",
                  name, bus.valid, bus.done, bus.sel, s);
      end
   endtask

   initial begin
      logic [15:0] m;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      bus.mode  = 1'b0;
      bus.dwell = 8'd0;
      bus.mask  = 16'h0;

      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      expect_idle(4'd0, "reset_state");

      run_scan(16'hFFFF, 0, 1'b1, 0, "full_single");
      run_scan(16'h8421, 2, 1'b0, 18, "sparse_cont");
      run_scan(16'h8421, 2, 1'b0, 5, "stop_mid");
      expect_idle(4'd5, "stop_hold");
      run_scan(16'h8421, 2, 1'b1, 0, "restart");
      run_scan(16'h0000, 3, 1'b1, 0, "mask0_single");
      run_scan(16'h0000, 1, 1'b0, 0, "mask0_cont");
      run_scan(16'h0010, 1, 1'b0, 9, "single_ch_cont");

      // start and stop together in IDLE must do nothing.
      @(posedge clk);
      #1;
      bus.mask  = 16'hFFFF;
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      repeat (2) @(posedge clk);
      expect_idle(last_sel, "start_stop_idle");

      // Channel 1 disabled during channel 0 dwell ends the pass there.
      @(posedge clk);
      #1;
      bus.mask  = 16'h0003;
      bus.dwell = 8'd3;
      bus.mode  = 1'b1;
      bus.start = 1'b1;
      for (int r = 0; r < 4; r++) exp_q.push_back({2'b10, 4'd0});
      exp_q.push_back({2'b01, 4'd0});
      last_sel = 4'd0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.mask  = 16'h0001;
      drain_check(20, "mask_drop");

      // Reset in the middle of a continuous scan.
      @(posedge clk);
      #1;
      bus.mask  = 16'hFFFF;
      bus.dwell = 8'd1;
      bus.mode  = 1'b0;
      bus.start = 1'b1;
      push_scan(16'hFFFF, 1, 1'b0, 100);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      last_sel = 4'd0;
      @(negedge clk);
      checks++;
      if ({bus.valid, bus.done, bus.sel, bus.a, bus.b, bus.c, bus.d} !== 10'd0) begin
         errors++;
         $display("FAIL reset_mid got v=%0b d=%0b sel=%0d exp all zero",
                  bus.valid, bus.done, bus.sel);
      end
      drain_check(5, "reset_quiet");

      for (int it = 0; it < 25; it++) begin
         case ($urandom_range(0, 7))
            0:       m = 16'h0;
            1, 2:    m = 16'($urandom) & 16'($urandom) & 16'($urandom);
            default: m = 16'($urandom);
         endcase
         run_scan(m, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 40), "random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
